// File: rtl/sma_pulse_pkg.sv
// rtl/sma_pulse_pkg.sv - register map, bit indices and FSM states for the SMA pulse generator
package sma_pulse_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_HIGH   = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_USE_GATE = 1;
  localparam int CTRL_IRQ_EN   = 2;

  localparam int STAT_DONE = 31;
  localparam int STAT_BUSY = 30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/sma_pulse_core.sv
// rtl/sma_pulse_core.sv - pulse FSM with phase counter, remaining counter and shadow registers
module sma_pulse_core
  import sma_pulse_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int NUM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             use_gate_i,
  input  logic             gate_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] high_i,
  input  logic [NUM_W-1:0] num_i,
  output logic             out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [NUM_W-1:0] remaining_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] rem_q, rem_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] per_eff;
  logic             active;
  logic             wrap;

  // Periods shorter than two cycles cannot hold both a high and low phase.
  always_comb begin
    per_eff = (period_i < CNT_W'(2)) ? CNT_W'(2) : period_i;
  end

  // State, counters, shadows and the registered output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      per_q   <= '0;
      high_q  <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      per_q   <= per_d;
      high_q  <= high_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
    end
  end

  // Next state: gate-low cycles freeze everything; shadows reload only on a wrap.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    per_d   = per_q;
    high_d  = high_q;
    num_d   = num_q;
    rem_d   = rem_q;
    out_d   = 1'b0;
    done_o  = 1'b0;
    active  = !(use_gate_i && !gate_i);
    wrap    = (phase_q == per_q - CNT_W'(1));
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          phase_d = '0;
          per_d   = per_eff;
          high_d  = high_i;
          num_d   = num_i;
          rem_d   = num_i;
        end
      end
      default: begin
        if (active) begin
          state_d = ST_RUN;
          out_d   = (phase_q < high_q);
          if (wrap) begin
            phase_d = '0;
            per_d   = per_eff;
            high_d  = high_i;
            if (num_q != '0) begin
              rem_d = rem_q - NUM_W'(1);
              if (rem_q == NUM_W'(1)) begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
              end
            end
          end else begin
            phase_d = phase_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_PAUSE;
        end
        if (stop_i) begin
          state_d = ST_IDLE;
          out_d   = 1'b0;
        end
      end
    endcase
  end

  assign out_o       = out_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign remaining_o = rem_q;

endmodule

// File: rtl/sma_pulse_gen.sv
// rtl/sma_pulse_gen.sv - Avalon-MM register file and read mux around the pulse core
module sma_pulse_gen
  import sma_pulse_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int NUM_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        gate_in,
  output logic        out_port,
  output logic        irq
);

  logic [2:0]       ctrl_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic [NUM_W-1:0] num_q;
  logic             done_q;
  logic             irq_q;
  logic             wr;
  logic             start;
  logic             stop;
  logic             busy;
  logic             core_done;
  logic [NUM_W-1:0] remaining;

  assign wr    = chipselect & ~write_n;
  // Only a 0->1 transition of RUN starts a train; rewriting 1 is ignored.
  assign start = wr && (address == ADDR_CTRL) && writedata[CTRL_RUN] && !ctrl_q[CTRL_RUN];
  assign stop  = wr && (address == ADDR_CTRL) && !writedata[CTRL_RUN];

  sma_pulse_core #(
    .CNT_W(CNT_W),
    .NUM_W(NUM_W)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start),
    .stop_i      (stop),
    .use_gate_i  (ctrl_q[CTRL_USE_GATE]),
    .gate_i      (gate_in),
    .period_i    (period_q),
    .high_i      (high_q),
    .num_i       (num_q),
    .out_o       (out_port),
    .busy_o      (busy),
    .done_o      (core_done),
    .remaining_o (remaining)
  );

  // Register writes; completion overrides a coincident RUN or DONE-clear write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      num_q    <= '0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr) begin
        case (address)
          ADDR_CTRL:   ctrl_q   <= writedata[2:0];
          ADDR_PERIOD: period_q <= writedata[CNT_W-1:0];
          ADDR_HIGH:   high_q   <= writedata[CNT_W-1:0];
          default: begin
            num_q  <= writedata[NUM_W-1:0];
            done_q <= 1'b0;
          end
        endcase
      end
      if (core_done) begin
        ctrl_q[CTRL_RUN] <= 1'b0;
        done_q           <= 1'b1;
      end
      irq_q <= done_q & ctrl_q[CTRL_IRQ_EN];
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata[2:0]       = ctrl_q;
      ADDR_PERIOD: readdata[CNT_W-1:0] = period_q;
      ADDR_HIGH:   readdata[CNT_W-1:0] = high_q;
      default: begin
        readdata[STAT_DONE]   = done_q;
        readdata[STAT_BUSY]   = busy;
        readdata[NUM_W-1:0]   = remaining;
      end
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_sma_pulse_gen.sv
// tb/tb_sma_pulse_gen.sv - randomized self-checking bench for sma_pulse_gen
module tb_sma_pulse_gen;
  import sma_pulse_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        gate_in;
  logic        out_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  sma_pulse_gen #(.CNT_W(32), .NUM_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .gate_in    (gate_in),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = ADDR_COUNT;
    #1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
    address = ADDR_COUNT;
    #1;
  endtask

  // Reference: the train is a pattern of total = n*peff bits, bit k = (k % peff) < h.
  // Each cycle the gate allows, one bit is consumed and shows on out_port a cycle later;
  // blocked cycles show 0. DONE appears the cycle after the last bit is consumed.
  task automatic run_pulses(input int p, input int h, input int n, input bit ug, input bit ien);
    int peff;
    int total;
    int pos;
    bit act;
    bit exp_out;
    logic [31:0] rd;
    peff  = (p < 2) ? 2 : p;
    total = n * peff;
    pos   = 0;
    gate_in = 1'b1;
    reg_write(ADDR_PERIOD, p);
    reg_write(ADDR_HIGH, h);
    reg_write(ADDR_COUNT, n);
    reg_write(ADDR_CTRL, (ien ? 32'd4 : 32'd0) | (ug ? 32'd2 : 32'd0) | 32'd1);
    check_eq("busy_start", readdata[STAT_BUSY], 1'b1);
    check_eq("rem_start", readdata[15:0], n);
    for (int cyc = 0; cyc < 2000 && pos < total; cyc++) begin
      gate_in = ug ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
      act     = !ug || gate_in;
      exp_out = act && ((pos % peff) < h);
      if (act) pos++;
      @(negedge clk);
      check_eq("out", out_port, exp_out);
      check_eq("busy", readdata[STAT_BUSY], pos < total);
      check_eq("done", readdata[STAT_DONE], pos == total);
      check_eq("irq_early", irq, 1'b0);
    end
    check_eq("train_len", pos, total);
    check_eq("rem_end", readdata[15:0], 0);
    gate_in = 1'b1;
    @(negedge clk);
    check_eq("out_after", out_port, 1'b0);
    check_eq("irq_rise", irq, ien);
    reg_read(ADDR_CTRL, rd);
    check_eq("run_cleared", rd[CTRL_RUN], 1'b0);
    reg_write(ADDR_COUNT, 0);
    check_eq("done_clr", readdata[STAT_DONE], 1'b0);
    check_eq("irq_hold", irq, ien);
    @(negedge clk);
    check_eq("irq_fall", irq, 1'b0);
  endtask

  logic [31:0] rd;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    address    = ADDR_COUNT;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    gate_in    = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_out", out_port, 1'b0);
    check_eq("rst_irq", irq, 1'b0);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      reg_read(2'(a), rd);
      check_eq("rst_reg", rd, 0);
    end

    // Directed cases from the register-level behaviour.
    run_pulses(10, 3, 4, 1'b0, 1'b0);
    run_pulses(5, 2, 1, 1'b0, 1'b1);
    run_pulses(8, 4, 1, 1'b1, 1'b0);
    run_pulses(0, 1, 3, 1'b0, 1'b0);
    run_pulses(6, 0, 2, 1'b0, 1'b1);
    run_pulses(10, 20, 2, 1'b0, 1'b0);

    // Randomized trains.
    for (int r = 0; r < 14; r++) begin
      run_pulses($urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(1, 4),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
    end

    // HIGH changed mid-period in continuous mode applies from the next period.
    reg_write(ADDR_PERIOD, 10);
    reg_write(ADDR_HIGH, 2);
    reg_write(ADDR_COUNT, 0);
    reg_write(ADDR_CTRL, 1);
    for (int k = 0; k < 25; k++) begin
      if (k == 0) begin
        chipselect = 1'b1; write_n = 1'b0; address = ADDR_HIGH; writedata = 6;
      end else if (k == 1) begin
        chipselect = 1'b0; write_n = 1'b1; address = ADDR_COUNT;
      end
      @(negedge clk);
      check_eq("high_change", out_port, (k < 10) ? (k < 2) : ((k % 10) < 6));
    end
    reg_write(ADDR_CTRL, 0);
    check_eq("stop_out", out_port, 1'b0);
    check_eq("stop_busy", readdata[STAT_BUSY], 1'b0);
    check_eq("stop_done", readdata[STAT_DONE], 1'b0);

    // Stop while the output is high.
    reg_write(ADDR_HIGH, 20);
    reg_write(ADDR_CTRL, 1);
    repeat (3) @(negedge clk);
    check_eq("mid_high", out_port, 1'b1);
    reg_write(ADDR_CTRL, 0);
    check_eq("mid_stop_out", out_port, 1'b0);
    check_eq("mid_stop_done", readdata[STAT_DONE], 1'b0);
    repeat (3) @(negedge clk);
    check_eq("mid_stop_idle", out_port, 1'b0);

    // Asynchronous reset while the output is high.
    reg_write(ADDR_COUNT, 3);
    reg_write(ADDR_CTRL, 5);
    repeat (4) @(negedge clk);
    check_eq("pre_reset_out", out_port, 1'b1);
    #2 reset = 1'b1;
    #1 check_eq("async_reset_out", out_port, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      reg_read(2'(a), rd);
      check_eq("post_reset_reg", rd, 0);
    end
    check_eq("post_reset_irq", irq, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sma_pulse_gen.md
# sma_pulse_gen

Avalon-MM slave pulse generator driving the SMA output connector. It sits directly downstream of the single-bit SMA PIO: the PIO's `out_port` enters here as `gate_in`, and this block produces the shaped pulse train on `out_port` toward the SMA pin. Software programs period, high width and pulse count over the same Nios II Avalon bus, then starts, gates or stops the train.

## Interface
Parameters:
- `CNT_W`, 32: width of PERIOD and HIGH registers and of the phase counter.
- `NUM_W`, 16: width of the pulse-count register and the remaining-pulse counter.

Ports:
- `clk`  input  1  system clock; the only clock.
- `reset`  input  1  reset; asynchronous, active-high.
- `address`  input  2  register select.
- `chipselect`  input  1  Avalon slave select.
- `write_n`  input  1  active-low write strobe.
- `writedata`  input  32  write data.
- `readdata`  output  32  read data; zero wait states.
- `gate_in`  input  1  gate from the SMA PIO; same `clk` domain, no synchronizer.
- `out_port`  output  1  pulse output to the SMA pin; registered.
- `irq`  output  1  done interrupt; level, registered.

## Operation
- Write = `chipselect & ~write_n`. `readdata` is a combinational mux on `address`. Reads have no side effects.
- Addr 0, CONTROL, R/W: bit0 RUN, bit1 USE_GATE, bit2 IRQ_EN. Other bits read 0.
- Addr 1, PERIOD, R/W: `CNT_W` bits. Values below 2 behave as 2.
- Addr 2, HIGH, R/W: `CNT_W` bits. 0 keeps the output low for the whole period. A value ≥ the effective period keeps it high for the whole period.
- Addr 3, COUNT/STATUS:
  - Write: loads NUM (`NUM_W` bits; 0 = continuous) and clears DONE.
  - Read: bit31 DONE, bit30 BUSY, bits[NUM_W-1:0] remaining pulses.
- FSM states: IDLE, RUN, PAUSE.
- IDLE → RUN: on the cycle after RUN is written from 0 to 1. On entry, PERIOD, HIGH and NUM are latched into shadow registers, the phase counter is set to 0 and remaining is set to NUM.
- RUN:
  - The phase counter increments each cycle.
  - `out_port` next value = (phase < HIGH_shadow).
  - At phase = PERIOD_shadow−1: phase wraps to 0, PERIOD and HIGH are re-latched (new values apply only at period boundaries), and remaining decrements if NUM ≠ 0.
  - When the decrement takes remaining to 0: go to IDLE, clear RUN, set DONE.
- RUN → PAUSE: when USE_GATE=1 and `gate_in`=0. In PAUSE the phase counter and remaining count freeze and `out_port` is forced to 0.
- PAUSE → RUN: when `gate_in`=1 or USE_GATE=0. The counter resumes from the frozen phase.
- Writing RUN=0 in RUN or PAUSE: go to IDLE next cycle with `out_port`=0. DONE is not set.
- Writing RUN=1 while already running: no restart.
- `irq` = DONE & IRQ_EN, registered.
- BUSY = (state ≠ IDLE).

## Timing
- Reset values: every register and shadow register 0; state IDLE; `out_port`=0; `irq`=0; `readdata` is the mux of zeroed registers.
- RUN write in cycle N: state is RUN at N+1 and `out_port` reflects phase 0 at N+2.
- Each pulse lasts exactly PERIOD_shadow cycles. The high time is min(HIGH, PERIOD) cycles.
- DONE is visible in STATUS in the cycle after the last period ends. `irq` rises one cycle after DONE.
- If a DONE-clearing write to addr 3 coincides with DONE being set, set wins.
- If a RUN=0 write coincides with the terminal period end, the result is IDLE with DONE set.
- Reset asserted mid-pulse: `out_port` drops to 0 asynchronously and all state returns to IDLE.

## Structure
- Package `sma_pulse_pkg`:
  - register address constants (CTRL=0, PERIOD=1, HIGH=2, COUNT=3);
  - CONTROL bit indices;
  - STATUS bit indices (DONE=31, BUSY=30);
  - the FSM state enum.
- Sub-module `sma_pulse_core` holds the FSM, phase counter, remaining counter and shadows. The top holds the Avalon register file and the read mux.

## Test plan
- PERIOD=10, HIGH=3, NUM=4, RUN=1 → 4 pulses, each high 3 cycles and low 7; then STATUS reads DONE=1, BUSY=0, and CONTROL bit0 reads 0.
- IRQ_EN=1, NUM=1 → `irq` rises 1 cycle after DONE. A write of 0 to addr 3 clears DONE, and `irq` falls on the next cycle.
- USE_GATE=1, PERIOD=8, HIGH=4; drop `gate_in` for 5 cycles mid-high → `out_port` is 0 during the gate-low window and the pulse resumes with its remaining high cycles; total elapsed time is 8+5 cycles.
- Change HIGH from 2 to 6 while continuous (NUM=0) at PERIOD=10 → the current period stays at 2 high cycles and the next period has 6.
- Boundaries: PERIOD=0 → 2-cycle period. HIGH=0 → constant 0. HIGH=20 with PERIOD=10 → constant 1. RUN=0 mid-pulse → `out_port`=0 next cycle and DONE stays 0.
- Assert `reset` asynchronously mid-pulse → `out_port`=0 immediately, and all registers read 0 after reset is released.
